// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB fade sequencer.
//   fade_state_e  : sequencer state (IDLE, FADE, HOLD)
//   rgb_flags_t   : one on/off flag per channel; expanded to full scale or zero
//   palette_flags : 8-entry palette lookup by index
package rgb_pkg;

  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } fade_state_e;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_flags_t;

  // Palette: 0 black, 1 red, 2 green, 3 blue, 4 yellow, 5 cyan, 6 magenta, 7 white
  function automatic rgb_flags_t palette_flags(input logic [IDX_W-1:0] idx);
    rgb_flags_t f;
    case (idx)
      3'd0:    f = rgb_flags_t'(3'b000);
      3'd1:    f = rgb_flags_t'(3'b100);
      3'd2:    f = rgb_flags_t'(3'b010);
      3'd3:    f = rgb_flags_t'(3'b001);
      3'd4:    f = rgb_flags_t'(3'b110);
      3'd5:    f = rgb_flags_t'(3'b011);
      3'd6:    f = rgb_flags_t'(3'b101);
      default: f = rgb_flags_t'(3'b111);
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_step_timer.sv
// Free-running fade-step prescaler.
//   clk, reset_n : block clock, asynchronous active-low reset
//   tick         : registered one-cycle pulse while the count sits at STEP_DIV-1
module step_timer #(
  parameter int unsigned STEP_DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt_c;

  // Wrapping count 0..STEP_DIV-1
  always_comb begin
    cnt_nxt_c = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
  end

  // tick is registered from the next count so it is high exactly while cnt == CNT_LAST
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt_c;
      tick <= (cnt_nxt_c == CNT_LAST);
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// RGB fade sequencer: owns the three PWM duty registers and fades them linearly
// between palette colours, chosen by the encoder (manual) or a palette walk (auto).
//   clk, reset_n        : block clock, asynchronous active-low reset
//   sel[4:0]            : encoder value, sel[2:0] is the palette index
//   auto_en             : 1 = auto palette walk, 0 = manual
//   red/green/blue_duty : registered duty outputs
//   cur_idx             : palette index of the current target
//   busy                : registered, high while fading
module rgb_fade_sequencer
  import rgb_pkg::*;
#(
  parameter int unsigned DUTY_W     = 8,
  parameter int unsigned STEP_DIV   = 1000,
  parameter int unsigned HOLD_STEPS = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        sel,
  input  logic              auto_en,
  output logic [DUTY_W-1:0] red_duty,
  output logic [DUTY_W-1:0] green_duty,
  output logic [DUTY_W-1:0] blue_duty,
  output logic [IDX_W-1:0]  cur_idx,
  output logic              busy
);

  localparam int unsigned HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  fade_state_e       state, state_d;
  rgb_flags_t        target, target_d;
  logic [IDX_W-1:0]  idx_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic [DUTY_W-1:0] red_d, green_d, blue_d;

  logic [IDX_W-1:0]  sel_s, sel_q;
  logic              auto_s, auto_q;
  logic              tick;

  logic              sel_chg_c, auto_rise_c, auto_fall_c;
  logic              sel_unused_c;

  // Only the palette index bits of the encoder value matter
  assign sel_unused_c = ^sel[4:3];

  step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Move one count toward the target, never past it
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    if (cur < tgt) return cur + DUTY_W'(1);
    if (cur > tgt) return cur - DUTY_W'(1);
    return cur;
  endfunction

  // Events are decoded from the sampled copies, giving the two-cycle input latency.
  // sel changes only count in manual mode; sel_q tracks sel regardless.
  assign sel_chg_c   = !auto_s && (sel_s != sel_q);
  assign auto_rise_c =  auto_s && !auto_q;
  assign auto_fall_c = !auto_s &&  auto_q;

  // Next-state, target, hold and duty logic
  always_comb begin
    state_d  = state;
    target_d = target;
    idx_d    = cur_idx;
    hold_d   = hold_cnt;
    red_d    = red_duty;
    green_d  = green_duty;
    blue_d   = blue_duty;

    case (state)
      IDLE: begin
        if (auto_rise_c) begin
          idx_d    = cur_idx + IDX_W'(1);
          target_d = palette_flags(idx_d);
          state_d  = FADE;
        end else if (sel_chg_c) begin
          idx_d    = sel_s;
          target_d = palette_flags(sel_s);
          state_d  = FADE;
        end
      end

      FADE: begin
        // Retarget in place: duties and tick phase carry on untouched
        if (auto_fall_c || sel_chg_c) begin
          idx_d    = sel_s;
          target_d = palette_flags(sel_s);
        end
        if ((red_duty   == {DUTY_W{target_d.r}}) &&
            (green_duty == {DUTY_W{target_d.g}}) &&
            (blue_duty  == {DUTY_W{target_d.b}})) begin
          state_d = auto_s ? HOLD : IDLE;
          hold_d  = '0;
        end else if (tick) begin
          red_d   = step_toward(red_duty,   {DUTY_W{target_d.r}});
          green_d = step_toward(green_duty, {DUTY_W{target_d.g}});
          blue_d  = step_toward(blue_duty,  {DUTY_W{target_d.b}});
        end
      end

      HOLD: begin
        if (auto_fall_c) begin
          idx_d    = sel_s;
          target_d = palette_flags(sel_s);
          state_d  = FADE;
        end else if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            idx_d    = cur_idx + IDX_W'(1);
            target_d = palette_flags(idx_d);
            hold_d   = '0;
            state_d  = FADE;
          end else begin
            hold_d = hold_cnt + HOLD_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, duty and input-sample registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      target     <= rgb_flags_t'(3'b000);
      cur_idx    <= '0;
      hold_cnt   <= '0;
      red_duty   <= '0;
      green_duty <= '0;
      blue_duty  <= '0;
      busy       <= 1'b0;
      sel_s      <= '0;
      sel_q      <= '0;
      auto_s     <= 1'b0;
      auto_q     <= 1'b0;
    end else begin
      state      <= state_d;
      target     <= target_d;
      cur_idx    <= idx_d;
      hold_cnt   <= hold_d;
      red_duty   <= red_d;
      green_duty <= green_d;
      blue_duty  <= blue_d;
      busy       <= (state_d == FADE);
      sel_s      <= sel[2:0];
      sel_q      <= sel_s;
      auto_s     <= auto_en;
      auto_q     <= auto_s;
    end
  end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer: a per-cycle behavioural model of the
// fade rules plus hand-computed literal checks, directed scenarios then random traffic.
module tb_rgb_fade_sequencer;

  localparam int DUTY_W     = 8;
  localparam int STEP_DIV   = 4;
  localparam int HOLD_STEPS = 3;
  localparam int FULL       = (1 << DUTY_W) - 1;
  localparam int M_IDLE     = 0;
  localparam int M_FADE     = 1;
  localparam int M_HOLD     = 2;
  localparam int LIT_N      = 256;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b1;
  logic [4:0]        sel     = 5'd0;
  logic              auto_en = 1'b0;
  logic [DUTY_W-1:0] red_duty, green_duty, blue_duty;
  logic [2:0]        cur_idx;
  logic              busy;

  rgb_fade_sequencer #(
    .DUTY_W     (DUTY_W),
    .STEP_DIV   (STEP_DIV),
    .HOLD_STEPS (HOLD_STEPS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sel        (sel),
    .auto_en    (auto_en),
    .red_duty   (red_duty),
    .green_duty (green_duty),
    .blue_duty  (blue_duty),
    .cur_idx    (cur_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Counters, written only by the compare process
  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Literal expectations queued by the stimulus, checked at the next falling edge.
  // sig: 0 red, 1 green, 2 blue, 3 cur_idx, 4 busy, 5 value carried in lit_act
  string lit_name [LIT_N];
  int    lit_sig  [LIT_N];
  int    lit_exp  [LIT_N];
  int    lit_act  [LIT_N];
  int    wr_ptr = 0;
  int    rd_ptr = 0;

  // Behavioural model state: colour is implied by palette index
  int m_mode, m_idx, m_hold, m_phase;
  int m_duty [3];
  int m_sel_s, m_sel_q;
  bit m_auto_s, m_auto_q;

  function automatic int pal(input int idx, input int c);
    int bits;
    case (idx)
      0: bits = 0;
      1: bits = 4;
      2: bits = 2;
      3: bits = 1;
      4: bits = 6;
      5: bits = 3;
      6: bits = 5;
      default: bits = 7;
    endcase
    return (((bits >> (2 - c)) & 1) != 0) ? FULL : 0;
  endfunction

  function automatic int sig_value(input int s, input int act);
    case (s)
      0: return int'(red_duty);
      1: return int'(green_duty);
      2: return int'(blue_duty);
      3: return int'(cur_idx);
      4: return int'(busy);
      default: return act;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_idx = 0; m_hold = 0; m_phase = 0;
    m_sel_s = 0; m_sel_q = 0; m_auto_s = 1'b0; m_auto_q = 1'b0;
    for (int c = 0; c < 3; c++) m_duty[c] = 0;
  endtask

  // Advance the model across the next rising edge using the inputs the DUT will sample
  task automatic model_step();
    bit tk, rise, fall, chg, done;
    tk   = (m_phase == STEP_DIV - 1);
    rise = m_auto_s && !m_auto_q;
    fall = !m_auto_s && m_auto_q;
    chg  = !m_auto_s && (m_sel_s != m_sel_q);
    case (m_mode)
      M_IDLE: begin
        if (rise) begin m_idx = (m_idx + 1) % 8; m_mode = M_FADE; end
        else if (chg) begin m_idx = m_sel_s; m_mode = M_FADE; end
      end
      M_FADE: begin
        if (fall || chg) m_idx = m_sel_s;
        done = 1'b1;
        for (int c = 0; c < 3; c++) if (m_duty[c] != pal(m_idx, c)) done = 1'b0;
        if (done) begin
          m_mode = m_auto_s ? M_HOLD : M_IDLE;
          m_hold = 0;
        end else if (tk) begin
          for (int c = 0; c < 3; c++) begin
            if (m_duty[c] < pal(m_idx, c)) m_duty[c] = m_duty[c] + 1;
            else if (m_duty[c] > pal(m_idx, c)) m_duty[c] = m_duty[c] - 1;
          end
        end
      end
      default: begin
        if (fall) begin m_idx = m_sel_s; m_mode = M_FADE; end
        else if (tk) begin
          m_hold = m_hold + 1;
          if (m_hold == HOLD_STEPS) begin
            m_idx = (m_idx + 1) % 8; m_mode = M_FADE; m_hold = 0;
          end
        end
      end
    endcase
    m_sel_q  = m_sel_s;
    m_sel_s  = int'(sel[2:0]);
    m_auto_q = m_auto_s;
    m_auto_s = auto_en;
    m_phase  = (m_phase + 1) % STEP_DIV;
  endtask

  // Compare process: model vs DUT every cycle, then queued literal checks
  always @(negedge clk) begin
    if (!reset_n) model_reset();
    if (cmp_en) begin
      check("red_duty",   int'(red_duty),   m_duty[0]);
      check("green_duty", int'(green_duty), m_duty[1]);
      check("blue_duty",  int'(blue_duty),  m_duty[2]);
      check("cur_idx",    int'(cur_idx),    m_idx);
      check("busy",       int'(busy),       (m_mode == M_FADE) ? 1 : 0);
    end
    while (rd_ptr < wr_ptr) begin
      check(lit_name[rd_ptr], sig_value(lit_sig[rd_ptr], lit_act[rd_ptr]), lit_exp[rd_ptr]);
      rd_ptr++;
    end
    if (reset_n) model_step();
  end

  task automatic expect_lit(input string name, input int s, input int exp, input int act = 0);
    if (wr_ptr < LIT_N) begin
      lit_name[wr_ptr] = name;
      lit_sig[wr_ptr]  = s;
      lit_exp[wr_ptr]  = exp;
      lit_act[wr_ptr]  = act;
      wr_ptr++;
    end
  endtask

  task automatic expect_rgb(input string name, input int r, input int g, input int b);
    expect_lit({name, "_red"},   0, r);
    expect_lit({name, "_green"}, 1, g);
    expect_lit({name, "_blue"},  2, b);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    reset_n = 1'b0;
    sel     = 5'd0;
    auto_en = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(1);
    cmp_en = 1'b1;
    expect_rgb("reset", 0, 0, 0);
    expect_lit("reset_idx", 3, 0);
    expect_lit("reset_busy", 4, 0);

    // First fade: black to red, busy rises two edges after sel changes
    sel = 5'd1;
    cycles(1);
    expect_lit("busy_lat1", 4, 0);
    cycles(1);
    expect_lit("busy_lat2", 4, 1);
    expect_lit("first_idx", 3, 1);
    cycles(1100);
    expect_rgb("red_done", FULL, 0, 0);
    expect_lit("red_done_busy", 4, 0);

    // Retarget mid-fade at red == 100
    sel = 5'd0;
    cycles(1100);
    expect_rgb("black", 0, 0, 0);
    sel = 5'd1;
    n = 0;
    while (red_duty != 8'd100 && n < 2000) begin cycles(1); n++; end
    if (n >= 2000) expect_lit("wait_red100_timeout", 5, 0, 1);
    sel = 5'd3;
    cycles(2);
    expect_lit("retarget_idx", 3, 3);
    expect_lit("retarget_busy", 4, 1);
    cycles(1100);
    expect_rgb("blue_done", 0, 0, FULL);

    // Auto walk from white: wraps to black, holds, then fades to red
    sel = 5'd7;
    cycles(1100);
    expect_rgb("white", FULL, FULL, FULL);
    expect_lit("white_idx", 3, 7);
    auto_en = 1'b1;
    cycles(2);
    expect_lit("auto_wrap_idx", 3, 0);
    expect_lit("auto_busy", 4, 1);
    n = 0;
    while (busy && n < 2000) begin cycles(1); n++; end
    if (n >= 2000) expect_lit("wait_hold_timeout", 5, 0, 1);
    expect_rgb("auto_black", 0, 0, 0);
    n = 0;
    while (!busy && n < 50) begin cycles(1); n++; end
    expect_lit("hold_len_9_to_12", 5, 1, (n >= 9 && n <= 12) ? 1 : 0);
    expect_lit("auto_next_idx", 3, 1);

    // sel is ignored while in auto mode
    for (int i = 0; i < 30; i++) begin
      sel = 5'($urandom_range(0, 31));
      cycles(int'($urandom_range(1, 150)));
    end

    // Dropping auto fades to palette[sel]
    sel = 5'd5;
    cycles(2);
    auto_en = 1'b0;
    cycles(1200);
    expect_rgb("cyan", 0, FULL, FULL);
    expect_lit("cyan_idx", 3, 5);
    expect_lit("cyan_busy", 4, 0);

    // Same palette index reselected: no fade
    sel = 5'd2;
    cycles(1100);
    expect_rgb("green", 0, FULL, 0);
    sel = 5'd10;
    cycles(3);
    expect_lit("same_idx_busy_a", 4, 0);
    expect_lit("same_idx_idx", 3, 2);
    cycles(5);
    expect_lit("same_idx_busy_b", 4, 0);
    sel = 5'd1;
    cycles(1100);
    expect_rgb("red_again", FULL, 0, 0);
    sel = 5'd10;
    cycles(1100);
    expect_rgb("green_from_10", 0, FULL, 0);
    expect_lit("green_from_10_idx", 3, 2);

    // Asynchronous reset mid-fade
    sel = 5'd7;
    cycles(50);
    #3;
    reset_n = 1'b0;
    sel     = 5'd0;
    expect_rgb("async_rst", 0, 0, 0);
    expect_lit("async_rst_idx", 3, 0);
    expect_lit("async_rst_busy", 4, 0);
    cycles(2);
    #3;
    reset_n = 1'b1;
    cycles(20);
    expect_lit("post_rst_busy", 4, 0);
    expect_lit("post_rst_red", 0, 0);
    sel = 5'd4;
    cycles(1100);
    expect_rgb("yellow", FULL, FULL, 0);
    expect_lit("yellow_idx", 3, 4);

    // Random traffic against the model
    for (int i = 0; i < 100; i++) begin
      case ($urandom_range(0, 3))
        0, 1: sel = 5'($urandom_range(0, 31));
        2:    auto_en = ~auto_en;
        default: ;
      endcase
      cycles(int'($urandom_range(1, 300)));
    end

    auto_en = 1'b0;
    sel = 5'd6;
    cycles(1200);
    expect_rgb("magenta", FULL, 0, FULL);
    expect_lit("magenta_idx", 3, 6);
    expect_lit("magenta_busy", 4, 0);

    cycles(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
